// File: rtl/mult_pipe_pkg.sv
// Shared types and default sizing for the pipelined wide multiplier.
package mult_pipe_pkg;

    localparam int DEF_WIDTH  = 256;
    localparam int DEF_LIMB_W = 27;
    localparam int DEF_TAG_W  = 8;

    typedef enum logic [1:0] {
        MODE_FULL = 2'd0,
        MODE_LOW  = 2'd1,
        MODE_HIGH = 2'd2
    } mode_e;

    // Limb count for slicing a w-bit operand; the last limb may be short.
    function automatic int num_limbs(input int w, input int lw);
        return (w + lw - 1) / lw;
    endfunction

endpackage

// File: rtl/mult_limb_tree.sv
// A_W x B_W product: one register stage of limb partial products, then a combinational shift-add tree.
// Latency 1 cycle (sum follows pp_q); holds its partial products while en is low.
module mult_limb_tree
    import mult_pipe_pkg::*;
#(
    parameter int A_W    = 128,
    parameter int B_W    = 256,
    parameter int LIMB_W = 27
) (
    input  logic                 clk,
    input  logic                 en,
    input  logic [A_W-1:0]       a,
    input  logic [B_W-1:0]       b,
    output logic [A_W+B_W-1:0]   sum
);

    localparam int NLIMB = num_limbs(B_W, LIMB_W);
    localparam int LVLS  = $clog2(NLIMB);
    localparam int NPAD  = 1 << LVLS;
    localparam int PP_W  = A_W + LIMB_W;
    localparam int RES_W = A_W + B_W;

    logic [PP_W-1:0] pp_d [NLIMB];
    logic [PP_W-1:0] pp_q [NLIMB];

    always_comb begin
        for (int i = 0; i < NLIMB; i++) begin
            pp_d[i] = PP_W'(a) * PP_W'(LIMB_W'(b >> (LIMB_W * i)));
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            pp_q <= pp_d;
        end
    end

    // Leaves are padded to a power of two with zeros; every node is full result width.
    for (genvar l = 0; l <= LVLS; l++) begin : g_lvl
        logic [RES_W-1:0] node [NPAD >> l];
        for (genvar j = 0; j < (NPAD >> l); j++) begin : g_node
            if (l == 0) begin : g_leaf
                if (j < NLIMB) begin : g_pp
                    assign node[j] = RES_W'(pp_q[j]) << (LIMB_W * j);
                end else begin : g_pad
                    assign node[j] = '0;
                end
            end else begin : g_add
                assign node[j] = g_lvl[l-1].node[2*j] + g_lvl[l-1].node[2*j+1];
            end
        end
    end

    assign sum = g_lvl[LVLS].node[0];

endmodule

// File: rtl/mult_pipe_param.sv
// Three-stage WIDTH x WIDTH multiplier with FULL/LOW/HIGH result select and tag sideband.
// Latency 3 cycles; one global stall freezes every stage while out_valid && !out_ready.
module mult_pipe_param
    import mult_pipe_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int LIMB_W = DEF_LIMB_W,
    parameter int TAG_W  = DEF_TAG_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     num1,
    input  logic [WIDTH-1:0]     num2,
    input  logic [1:0]           mode,
    input  logic [TAG_W-1:0]     tag_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic [TAG_W-1:0]     tag_out
);

    localparam int HALF  = WIDTH / 2;
    localparam int SUM_W = HALF + WIDTH;
    localparam int P_W   = 2 * WIDTH;

    logic               enable;
    logic               s1_vld_d, s1_vld_q;
    logic [HALF-1:0]    num1_hi_d, num1_hi_q;
    logic [WIDTH-1:0]   num2_d, num2_q;
    logic [1:0]         mode1_d, mode1_q;
    logic [TAG_W-1:0]   tag1_d, tag1_q;
    logic               s2_vld_d, s2_vld_q;
    logic [SUM_W-1:0]   lo_sum, hi_sum, lo_sum_d, lo_sum_q;
    logic [1:0]         mode2_d, mode2_q;
    logic [TAG_W-1:0]   tag2_d, tag2_q;
    logic               out_vld_d, out_vld_q;
    logic [P_W-1:0]     full_prod, product_d, product_q;
    logic [TAG_W-1:0]   tag_out_d, tag_out_q;

    assign enable    = !out_vld_q || out_ready;
    assign in_ready  = enable;
    assign out_valid = out_vld_q;
    assign product   = product_q;
    assign tag_out   = tag_out_q;

    // Low half of num1 is consumed at S1; the high half rides along to S2.
    mult_limb_tree #(.A_W(HALF), .B_W(WIDTH), .LIMB_W(LIMB_W)) u_lo (
        .clk (clk),
        .en  (enable),
        .a   (num1[HALF-1:0]),
        .b   (num2),
        .sum (lo_sum)
    );

    mult_limb_tree #(.A_W(HALF), .B_W(WIDTH), .LIMB_W(LIMB_W)) u_hi (
        .clk (clk),
        .en  (enable),
        .a   (num1_hi_q),
        .b   (num2_q),
        .sum (hi_sum)
    );

    always_comb begin
        s1_vld_d  = s1_vld_q;
        num1_hi_d = num1_hi_q;
        num2_d    = num2_q;
        mode1_d   = mode1_q;
        tag1_d    = tag1_q;
        s2_vld_d  = s2_vld_q;
        lo_sum_d  = lo_sum_q;
        mode2_d   = mode2_q;
        tag2_d    = tag2_q;
        out_vld_d = out_vld_q;
        product_d = product_q;
        tag_out_d = tag_out_q;
        full_prod = P_W'(lo_sum_q) + (P_W'(hi_sum) << HALF);
        if (enable) begin
            s1_vld_d  = in_valid;
            num1_hi_d = num1[WIDTH-1:HALF];
            num2_d    = num2;
            mode1_d   = mode;
            tag1_d    = tag_in;
            s2_vld_d  = s1_vld_q;
            lo_sum_d  = lo_sum;
            mode2_d   = mode1_q;
            tag2_d    = tag1_q;
            out_vld_d = s2_vld_q;
            tag_out_d = tag2_q;
            case (mode2_q)
                MODE_LOW:  product_d = {{WIDTH{1'b0}}, full_prod[WIDTH-1:0]};
                MODE_HIGH: product_d = {{WIDTH{1'b0}}, full_prod[P_W-1:WIDTH]};
                default:   product_d = full_prod;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q  <= 1'b0;
            s2_vld_q  <= 1'b0;
            out_vld_q <= 1'b0;
            product_q <= '0;
            tag_out_q <= '0;
        end else begin
            s1_vld_q  <= s1_vld_d;
            s2_vld_q  <= s2_vld_d;
            out_vld_q <= out_vld_d;
            product_q <= product_d;
            tag_out_q <= tag_out_d;
        end
    end

    always_ff @(posedge clk) begin
        num1_hi_q <= num1_hi_d;
        num2_q    <= num2_d;
        mode1_q   <= mode1_d;
        tag1_q    <= tag1_d;
        lo_sum_q  <= lo_sum_d;
        mode2_q   <= mode2_d;
        tag2_q    <= tag2_d;
    end

endmodule
